// File: rtl/branch_predict_resolve_unit.sv
// rtl/branch_predict_resolve_unit.sv - branch resolve, next-PC and bimodal predictor
// Registered predict and resolve paths sharing a table of 2-bit saturating counters.
module branch_predict_resolve_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DISP_WIDTH  = 16,
  parameter int BHT_ENTRIES = 64,
  parameter int INSN_SHIFT  = 2,
  parameter int PC_INC      = 4
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  flush,
  input  logic                  predReq,
  input  logic [ADDR_WIDTH-1:0] predPc,
  output logic                  predOutValid,
  output logic                  predTaken,
  input  logic                  resValid,
  input  logic [ADDR_WIDTH-1:0] resPc,
  input  logic [2:0]            resBrCode,
  input  logic [DATA_WIDTH-1:0] resRS,
  input  logic [DATA_WIDTH-1:0] resRT,
  input  logic [DISP_WIDTH-1:0] resConstant,
  input  logic                  resPredTaken,
  output logic                  resOutValid,
  output logic                  resTaken,
  output logic [ADDR_WIDTH-1:0] resPcOut,
  output logic                  resMispredict
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  localparam logic [2:0] BR_EQ    = 3'd0;
  localparam logic [2:0] BR_NE    = 3'd1;
  localparam logic [2:0] BR_LT    = 3'd2;
  localparam logic [2:0] BR_GE    = 3'd3;
  localparam logic [2:0] BR_LTU   = 3'd4;
  localparam logic [2:0] BR_GEU   = 3'd5;
  localparam logic [2:0] BR_TAKEN = 3'd6;

  // Counters packed two bits per entry so the whole table resets in one assignment.
  logic [2*BHT_ENTRIES-1:0] r_bht;

  logic [IDX_W-1:0]      w_pred_idx;
  logic [IDX_W-1:0]      w_res_idx;
  logic [1:0]            w_pred_ctr;
  logic [1:0]            w_res_ctr;
  logic [1:0]            w_res_ctr_next;
  logic                  w_cond;
  logic                  w_pred_fire;
  logic                  w_res_fire;
  logic                  w_upd;
  logic [ADDR_WIDTH-1:0] w_disp;
  logic [ADDR_WIDTH-1:0] w_next_pc;

  assign w_pred_idx  = predPc[INSN_SHIFT +: IDX_W];
  assign w_res_idx   = resPc[INSN_SHIFT +: IDX_W];
  assign w_pred_ctr  = r_bht[{w_pred_idx, 1'b0} +: 2];
  assign w_res_ctr   = r_bht[{w_res_idx, 1'b0} +: 2];
  assign w_pred_fire = predReq && !flush;
  assign w_res_fire  = resValid && !flush;
  assign w_upd       = w_res_fire && (resBrCode <= BR_GEU);

  always_comb begin
    w_cond = 1'b0;
    case (resBrCode)
      BR_EQ:    w_cond = (resRS == resRT);
      BR_NE:    w_cond = (resRS != resRT);
      BR_LT:    w_cond = ($signed(resRS) <  $signed(resRT));
      BR_GE:    w_cond = ($signed(resRS) >= $signed(resRT));
      BR_LTU:   w_cond = (resRS <  resRT);
      BR_GEU:   w_cond = (resRS >= resRT);
      BR_TAKEN: w_cond = 1'b1;
      default:  w_cond = 1'b0;
    endcase
  end

  assign w_disp    = ADDR_WIDTH'($signed(resConstant)) << INSN_SHIFT;
  assign w_next_pc = resPc + ADDR_WIDTH'(PC_INC) + (w_cond ? w_disp : '0);

  always_comb begin
    w_res_ctr_next = w_res_ctr;
    if (w_cond) begin
      if (w_res_ctr != 2'b11) w_res_ctr_next = w_res_ctr + 2'd1;
    end else begin
      if (w_res_ctr != 2'b00) w_res_ctr_next = w_res_ctr - 2'd1;
    end
  end

  // Prediction reads the pre-edge counter, so a same-cycle update to that entry is not seen.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_bht <= {BHT_ENTRIES{2'b01}};
    end else if (w_upd) begin
      r_bht[{w_res_idx, 1'b0} +: 2] <= w_res_ctr_next;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      predOutValid  <= 1'b0;
      predTaken     <= 1'b0;
      resOutValid   <= 1'b0;
      resTaken      <= 1'b0;
      resPcOut      <= '0;
      resMispredict <= 1'b0;
    end else begin
      predOutValid  <= w_pred_fire;
      predTaken     <= w_pred_fire && w_pred_ctr[1];
      resOutValid   <= w_res_fire;
      resTaken      <= w_res_fire && w_cond;
      resPcOut      <= w_res_fire ? w_next_pc : '0;
      resMispredict <= w_res_fire && (w_cond != resPredTaken);
    end
  end

endmodule

// File: tb/tb_branch_predict_resolve_unit.sv
// tb/tb_branch_predict_resolve_unit.sv - directed and model-checked bench for branch_predict_resolve_unit
// A table-level model is advanced on each edge and compared against the DUT every falling edge.
module tb_branch_predict_resolve_unit;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        flush = 1'b0;
  logic        predReq = 1'b0;
  logic [31:0] predPc = '0;
  logic        predOutValid;
  logic        predTaken;
  logic        resValid = 1'b0;
  logic [31:0] resPc = '0;
  logic [2:0]  resBrCode = '0;
  logic [31:0] resRS = '0;
  logic [31:0] resRT = '0;
  logic [15:0] resConstant = '0;
  logic        resPredTaken = 1'b0;
  logic        resOutValid;
  logic        resTaken;
  logic [31:0] resPcOut;
  logic        resMispredict;

  int nvec = 0;
  int nfail = 0;

  branch_predict_resolve_unit dut (
    .clk(clk), .rstN(rstN), .flush(flush),
    .predReq(predReq), .predPc(predPc),
    .predOutValid(predOutValid), .predTaken(predTaken),
    .resValid(resValid), .resPc(resPc), .resBrCode(resBrCode),
    .resRS(resRS), .resRT(resRT), .resConstant(resConstant),
    .resPredTaken(resPredTaken),
    .resOutValid(resOutValid), .resTaken(resTaken),
    .resPcOut(resPcOut), .resMispredict(resMispredict)
  );

  always #5 clk = ~clk;

  // Model: counters as plain integers 0..3, expected outputs as integers.
  int          m_bht [64];
  int          e_pv = 0, e_pt = 0, e_rv = 0, e_rt = 0, e_mp = 0;
  logic [31:0] e_pc = '0;

  function automatic int m_taken(int code, logic [31:0] rs, logic [31:0] rt);
    case (code)
      0: return int'(rs == rt);
      1: return int'(rs != rt);
      2: return int'(int'(rs) < int'(rt));
      3: return int'(int'(rs) >= int'(rt));
      4: return int'(rs < rt);
      5: return int'(rs >= rt);
      6: return 1;
      default: return 0;
    endcase
  endfunction

  initial for (int i = 0; i < 64; i++) m_bht[i] = 1;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < 64; i++) m_bht[i] = 1;
      e_pv = 0; e_pt = 0; e_rv = 0; e_rt = 0; e_mp = 0; e_pc = '0;
    end else begin
      int pi, ri, tk;
      logic [31:0] d;
      pi = int'((predPc / 4) % 64);
      ri = int'((resPc / 4) % 64);
      e_pv = int'(predReq && !flush);
      e_pt = (e_pv != 0) ? m_bht[pi] / 2 : 0;
      e_rv = int'(resValid && !flush);
      tk = m_taken(int'(resBrCode), resRS, resRT);
      d = {{16{resConstant[15]}}, resConstant} * 4;
      e_rt = (e_rv != 0) ? tk : 0;
      e_pc = (e_rv != 0) ? resPc + 32'd4 + (tk != 0 ? d : 32'd0) : 32'd0;
      e_mp = (e_rv != 0) ? int'(tk != int'(resPredTaken)) : 0;
      if (e_rv != 0 && resBrCode <= 3'd5) begin
        if (tk != 0) m_bht[ri] = (m_bht[ri] < 3) ? m_bht[ri] + 1 : 3;
        else         m_bht[ri] = (m_bht[ri] > 0) ? m_bht[ri] - 1 : 0;
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("predOutValid", 32'(predOutValid), 32'(e_pv));
    chk("predTaken", 32'(predTaken), 32'(e_pt));
    chk("resOutValid", 32'(resOutValid), 32'(e_rv));
    chk("resTaken", 32'(resTaken), 32'(e_rt));
    chk("resPcOut", resPcOut, e_pc);
    chk("resMispredict", 32'(resMispredict), 32'(e_mp));
  end

  task automatic idle();
    predReq = 1'b0; resValid = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pred(logic [31:0] pc);
    predReq = 1'b1; predPc = pc;
  endtask

  task automatic res(logic [31:0] pc, logic [2:0] code, logic [31:0] rs, logic [31:0] rt,
                     logic [15:0] c, logic pt);
    resValid = 1'b1; resPc = pc; resBrCode = code; resRS = rs; resRT = rt;
    resConstant = c; resPredTaken = pt;
  endtask

  task automatic chk_res(string name, logic v, logic t, logic [31:0] pc, logic mp);
    chk({name, ".valid"}, 32'(resOutValid), 32'(v));
    chk({name, ".taken"}, 32'(resTaken), 32'(t));
    chk({name, ".pc"}, resPcOut, pc);
    chk({name, ".mispredict"}, 32'(resMispredict), 32'(mp));
  endtask

  task automatic chk_pred(string name, logic v, logic t);
    chk({name, ".valid"}, 32'(predOutValid), 32'(v));
    chk({name, ".taken"}, 32'(predTaken), 32'(t));
  endtask

  logic [31:0] ops [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h5};

  initial begin
    repeat (2) tick();
    chk_pred("reset_pred", 1'b0, 1'b0);
    chk_res("reset_res", 1'b0, 1'b0, 32'h0, 1'b0);
    #2 rstN = 1'b1;
    tick();

    pred(32'h200); tick(); idle();
    chk_pred("first_pred", 1'b1, 1'b0);
    chk_res("first_res_idle", 1'b0, 1'b0, 32'h0, 1'b0);

    res(32'h100, 3'd0, 32'd5, 32'd5, 16'h0010, 1'b0); tick(); idle();
    chk_res("eq_fwd", 1'b1, 1'b1, 32'h144, 1'b1);
    res(32'h100, 3'd0, 32'd5, 32'd5, 16'hFFFF, 1'b0); tick(); idle();
    chk_res("eq_back", 1'b1, 1'b1, 32'h100, 1'b1);

    res(32'h104, 3'd2, 32'hFFFF_FFFF, 32'd1, 16'h0010, 1'b1); tick(); idle();
    chk_res("lt", 1'b1, 1'b1, 32'h148, 1'b0);
    res(32'h104, 3'd4, 32'hFFFF_FFFF, 32'd1, 16'h0010, 1'b1); tick(); idle();
    chk_res("ltu", 1'b1, 1'b0, 32'h108, 1'b1);
    res(32'h104, 3'd5, 32'hFFFF_FFFF, 32'd1, 16'h0010, 1'b0); tick(); idle();
    chk_res("geu", 1'b1, 1'b1, 32'h148, 1'b1);
    res(32'h104, 3'd3, 32'hFFFF_FFFF, 32'd1, 16'h0010, 1'b0); tick();
    // Asynchronous reset landing between edges while outputs are live.
    #2 rstN = 1'b0;
    #1;
    idle();
    chk_res("async_reset", 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    rstN = 1'b1;
    tick();

    res(32'h200, 3'd0, 32'd7, 32'd7, 16'h0, 1'b0); tick();
    res(32'h200, 3'd0, 32'd7, 32'd7, 16'h0, 1'b1); tick(); idle();
    pred(32'h200); tick(); idle();
    chk_pred("sat_hi", 1'b1, 1'b1);
    res(32'h200, 3'd1, 32'd7, 32'd7, 16'h0, 1'b1); tick(); idle();
    chk_res("ne_not_taken", 1'b1, 1'b0, 32'h204, 1'b1);
    pred(32'h200); tick(); idle();
    chk_pred("ctr10", 1'b1, 1'b1);
    pred(32'h300); tick(); idle();
    chk_pred("alias", 1'b1, 1'b1);

    pred(32'h208); res(32'h208, 3'd0, 32'd1, 32'd1, 16'h0, 1'b0); tick(); idle();
    chk_pred("rbw_same", 1'b1, 1'b0);
    pred(32'h208); tick(); idle();
    chk_pred("rbw_after", 1'b1, 1'b1);

    res(32'hFFFF_FFFC, 3'd6, 32'd0, 32'd9, 16'h0, 1'b1); tick(); idle();
    chk_res("wrap_taken", 1'b1, 1'b1, 32'h0, 1'b0);
    pred(32'hFFFF_FFFC); tick(); idle();
    chk_pred("taken_no_upd", 1'b1, 1'b0);
    res(32'h40, 3'd7, 32'd3, 32'd3, 16'h0010, 1'b1); tick(); idle();
    chk_res("none_mp", 1'b1, 1'b0, 32'h44, 1'b1);

    flush = 1'b1; pred(32'h20C); res(32'h20C, 3'd0, 32'd2, 32'd2, 16'h0, 1'b0); tick(); idle();
    chk_pred("flush_pred", 1'b0, 1'b0);
    chk_res("flush_res", 1'b0, 1'b0, 32'h0, 1'b0);
    res(32'h20C, 3'd0, 32'd2, 32'd2, 16'h0, 1'b0); tick(); idle();
    pred(32'h20C); tick(); idle();
    chk_pred("flush_no_upd", 1'b1, 1'b1);

    for (int i = 0; i < 60; i++) begin
      predReq = 1'($urandom_range(0, 3) != 0);
      predPc = {22'h0, 4'($urandom_range(0, 15)), 6'h0} | (32'($urandom_range(0, 3)) << 2);
      resValid = 1'($urandom_range(0, 3) != 0);
      resPc = {22'h0, 4'($urandom_range(0, 15)), 6'h0} | (32'($urandom_range(0, 3)) << 2);
      resBrCode = 3'($urandom_range(0, 7));
      resRS = ops[$urandom_range(0, 5)];
      resRT = ops[$urandom_range(0, 5)];
      resConstant = 16'($urandom);
      resPredTaken = 1'($urandom_range(0, 1));
      flush = 1'($urandom_range(0, 7) == 0);
      tick();
    end
    idle();
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
